apb_rr_master: RTL
==================

Name: apb_rr_master

Overview:
- Shares one APB slave port among N_REQ simple request/response clients; the typical slave is a read-only register bank.
- Arbitrates round-robin, latches the winner's transfer, drives the APB SETUP/ACCESS sequence and routes the registered response back to the winner.
- Sits between internal control engines (DMA, debug, status pollers) and a peripheral APB segment.

Parameters:
- N_REQ, 2, number of requesters (>=1; 1 = pass-through sequencer).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width (multiple of 8).

Ports:
- pclk_i  in  1  clock.
- preset_i  in  1  synchronous active-high reset.
- req_valid_i  in  N_REQ  per-requester transfer request.
- req_ready_o  out  N_REQ  one-hot accept pulse.
- req_addr_i  in  N_REQ*ADDR_WIDTH  byte addresses.
- req_write_i  in  N_REQ  1 = write.
- req_wdata_i  in  N_REQ*DATA_WIDTH  write data.
- req_strb_i  in  N_REQ*DATA_WIDTH/8  write strobes.
- rsp_valid_o  out  N_REQ  one-hot response pulse.
- rsp_rdata_o  out  DATA_WIDTH  read data, shared, qualified by rsp_valid_o.
- rsp_err_o  out  1  slave error, qualified by rsp_valid_o.
- paddr_o  out  ADDR_WIDTH  APB address.
- pprot_o  out  3  tied 3'b000.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB strobes; forced 0 on reads.
- pready_i  in  1  APB ready.
- prdata_i  in  DATA_WIDTH  APB read data.
- pslverr_i  in  1  APB slave error.

Behaviour:
- One clock (pclk_i); reset is synchronous and active-high (preset_i). All state changes on the rising edge of pclk_i.
- Reset values:
  - FSM = IDLE; RR pointer = 0.
  - psel_o, penable_o, rsp_valid_o = 0.
  - paddr_o, pwdata_o, pstrb_o, pwrite_o, rsp_rdata_o, rsp_err_o = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid_i is set, pick index g = first set bit searching from ptr upward, wrapping mod N_REQ.
  - req_ready_o[g] = 1 combinationally in that cycle; all other bits 0. req_ready_o is only ever asserted in IDLE.
  - Latch g and the winner's addr/write/wdata/strb; move to SETUP.
  - Update ptr = (g+1) mod N_REQ.
- SETUP: psel_o=1, penable_o=0, with the latched address/controls. Always advance to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - Hold every APB output stable while pready_i=0; no timeout.
  - On pready_i=1, register prdata_i into rsp_rdata_o (reads only; writes leave it unchanged) and pslverr_i into rsp_err_o. Pulse rsp_valid_o[g] in the next cycle. Go to IDLE.
- APB outputs are registered; psel_o/penable_o drop to 0 in the cycle after pready_i.
- Latency: grant at T, SETUP at T+1, ACCESS at T+2. With zero wait states, rsp_valid at T+3, and IDLE at T+3 may grant again. Peak rate is 1 transfer per 3 cycles.
- req_valid_i may drop without acceptance; a dropped request is not remembered.
- A requester re-asserting in the same cycle as its own rsp_valid_o is legal.
- Simultaneous requests: exactly one grant per IDLE cycle.
  - No requester waits more than N_REQ-1 other transfers.
- Reset mid-transfer:
  - The FSM returns to IDLE and psel_o/penable_o are 0 in the cycle after reset.
  - The in-flight transfer produces no response; the requester must reissue.
- ptr wraps N_REQ-1 -> 0. With N_REQ=1, ptr stays 0.
- Assertions (simulation only):
  - req_ready_o and rsp_valid_o are each one-hot or zero.
  - APB outputs stable during ACCESS wait states.
  - N_REQ >= 1.

Decomposition:
- Package apb_rr_pkg: state_e enum {IDLE, SETUP, ACCESS}; idx_t = logic[$clog2(N_REQ)-1:0], with a width-1 guard for N_REQ=1.
- Sub-module apb_rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: valid, idx, one-hot.
  - Reusable elsewhere.

Test Plan:
- Single read, requester 0, addr 0x8, slave returns 0xCAFE_F00D with no wait states -> req_ready_o=01 at T; psel at T+1; penable at T+2; rsp_valid_o=01 at T+3 with rdata 0xCAFE_F00D, err=0.
- Requesters 0 and 1 held valid for 4 transfers -> grant order 0,1,0,1; no back-to-back repeat; psel_o gap of 1 cycle between transfers.
- Write to a read-only slave (pslverr_i=1), data 0x1234, strb 0xF -> pwdata_o=0x1234, pstrb_o=0xF; rsp_err_o=1 on the response pulse; rsp_rdata_o unchanged from the previous read.
- Slave inserts 3 wait states -> paddr/pwrite/pwdata/penable stable for 4 ACCESS cycles; response exactly 1 cycle after pready_i.
- preset_i asserted during ACCESS -> psel_o=0 next cycle; no rsp_valid_o; ptr=0; a fresh request afterwards completes normally.
- N_REQ=3, only requester 2 repeatedly valid -> granted every 3 cycles; ptr wraps to 0 after each grant.

Source files
------------

// File: rtl/apb_rr_pkg.sv
// Shared types and helpers for the round-robin APB master.
// Pure declarations: no logic, no latency.
// No flow control lives here.
package apb_rr_pkg;

  // Transfer sequencer states: arbitrate, APB setup phase, APB access phase.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Requester index width. A single requester still gets a 1-bit index so
  // that idx_t (logic [idx_w(N_REQ)-1:0]) is never zero-width.
  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping mod N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module apb_rr_pick
  import apb_rr_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             vld_o,
  output logic [IW-1:0]    idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  typedef logic [IW-1:0] idx_t;

  idx_t cand;

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_i) + i) % N_REQ);
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

  // One-hot view of the chosen index.
  always_comb begin
    onehot_o = '0;
    if (vld_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB slave among N_REQ request/response clients, round-robin.
// Latency: grant T, SETUP T+1, ACCESS T+2, response one cycle after pready_i.
// Backpressure: one transfer in flight; requests are only accepted in IDLE.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SW = DATA_WIDTH / 8,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic                       pclk_i,
  input  logic                       preset_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ-1:0]           req_write_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [N_REQ*SW-1:0]        req_strb_i,
  output logic [N_REQ-1:0]           rsp_valid_o,
  output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic [ADDR_WIDTH-1:0]      paddr_o,
  output logic [2:0]                 pprot_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic [DATA_WIDTH-1:0]      pwdata_o,
  output logic [SW-1:0]              pstrb_o,
  input  logic                       pready_i,
  input  logic [DATA_WIDTH-1:0]      prdata_i,
  input  logic                       pslverr_i
);

  typedef logic [IW-1:0] idx_t;

  state_e                  state_q, state_d;
  idx_t                    ptr_q, ptr_d;
  idx_t                    gidx_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [SW-1:0]           pstrb_q;
  logic [N_REQ-1:0]        rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    pick_vld;
  idx_t                    pick_idx;
  logic [N_REQ-1:0]        pick_oh;
  logic                    accept;
  logic                    done;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    win_write;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic [SW-1:0]           win_strb;

  apb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .vld_o    (pick_vld),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  assign accept = (state_q == IDLE) && pick_vld;
  assign done   = (state_q == ACCESS) && pready_i;

  // Slice the winning requester's transfer out of the packed request buses.
  always_comb begin
    win_addr  = req_addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_write = req_write_i[pick_idx];
    win_wdata = req_wdata_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
    win_strb  = req_strb_i[int'(pick_idx)*SW +: SW];
  end

  // FSM state register.
  always_ff @(posedge pclk_i) begin
    if (preset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: SETUP always lasts one cycle, ACCESS waits for pready_i.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant only in IDLE; psel/penable decode the registered state.
  always_comb begin
    req_ready_o = '0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    case (state_q)
      IDLE:   req_ready_o = pick_oh;
      SETUP:  psel_o = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointer advance past the winner and the response pulse for the owner.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IW'(1);
    rsp_vld_d = '0;
    if (done) rsp_vld_d[gidx_q] = 1'b1;
  end

  // Transfer latch on accept, response capture on completion.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      ptr_q     <= '0;
      gidx_q    <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rsp_vld_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rsp_vld_q <= rsp_vld_d;
      if (accept) begin
        gidx_q   <= pick_idx;
        paddr_q  <= win_addr;
        pwrite_q <= win_write;
        pwdata_q <= win_wdata;
        pstrb_q  <= win_write ? win_strb : '0;
      end
      if (done) begin
        if (!pwrite_q) rdata_q <= prdata_i;
        err_q <= pslverr_i;
      end
    end
  end

  assign paddr_o     = paddr_q;
  assign pprot_o     = 3'b000;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  a_ready_onehot: assert property (@(posedge pclk_i) disable iff (preset_i) $onehot0(req_ready_o));
  a_rsp_onehot:   assert property (@(posedge pclk_i) disable iff (preset_i) $onehot0(rsp_valid_o));
  a_access_hold:  assert property (@(posedge pclk_i) disable iff (preset_i)
                    (state_q == ACCESS && !pready_i) |=>
                    ($stable(paddr_o) && $stable(pwrite_o) && $stable(pwdata_o) &&
                     $stable(pstrb_o) && psel_o && penable_o));
  a_n_req:        assert property (@(posedge pclk_i) N_REQ >= 1);

endmodule
